// File: rtl/output_adc.sv
// Multi-lane serial ADC reader: on a start/finish toggle handshake it runs one
// convert-then-shift cycle across NUM_COL lanes and publishes the captured words.
module output_adc #(
    parameter int unsigned NUM_COL = 8,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned CONV_T  = 40
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [NUM_COL-1:0]               SDO,
    output logic                             CS_N,
    output logic                             SCLK,
    output logic [NUM_COL-1:0][DATA_W-1:0]   ADC_DATA,
    output logic                             finish,
    output logic                             busy
);

    localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_e;

    state_e                           state_q, state_d;
    logic [7:0]                       conv_cnt_q, conv_cnt_d;
    logic [BitCntW-1:0]               bit_cnt_q, bit_cnt_d;
    logic                             cs_n_q, cs_n_d;
    logic                             sclk_q, sclk_d;
    logic                             finish_q, finish_d;
    logic [NUM_COL-1:0][DATA_W-1:0]   shift_q, shift_d;
    logic [NUM_COL-1:0][DATA_W-1:0]   adc_data_q, adc_data_d;

    logic pending;
    logic conv_last;
    logic bit_last;

    assign pending   = start ^ finish_q;
    assign conv_last = (conv_cnt_q == 8'(CONV_T - 1));
    assign bit_last  = (bit_cnt_q == BitCntW'(DATA_W - 1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at from idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pending) state_d = StConv;
            StConv:  if (conv_last) state_d = StShift;
            StShift: if (sclk_q && bit_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            finish_q   <= 1'b0;
            shift_q    <= '0;
            adc_data_q <= '0;
        end else begin
            conv_cnt_q <= conv_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            finish_q   <= finish_d;
            shift_q    <= shift_d;
            adc_data_q <= adc_data_d;
        end
    end

    always_comb begin
        conv_cnt_d = conv_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        finish_d   = finish_q;
        shift_d    = shift_q;
        adc_data_d = adc_data_q;
        unique case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (pending) begin
                    cs_n_d     = 1'b0;
                    conv_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end
            end
            StConv: begin
                if (conv_last) begin
                    sclk_d = 1'b1;
                end else begin
                    conv_cnt_d = conv_cnt_q + 8'd1;
                end
            end
            StShift: begin
                // Sample on the edge that drops SCLK; the ADC moves SDO on that falling edge
                if (sclk_q) begin
                    sclk_d = 1'b0;
                    for (int i = 0; i < int'(NUM_COL); i++) begin
                        shift_d[i] = {shift_q[i][DATA_W-2:0], SDO[i]};
                    end
                    if (!bit_last) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    sclk_d = 1'b1;
                end
            end
            StDone: begin
                adc_data_d = shift_q;
                finish_d   = ~finish_q;
                cs_n_d     = 1'b1;
                sclk_d     = 1'b0;
            end
            default: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        CS_N     = cs_n_q;
        SCLK     = sclk_q;
        finish   = finish_q;
        ADC_DATA = adc_data_q;
        busy     = (state_q != StIdle);
    end

endmodule

// File: doc/output_adc.md
OUTPUT_ADC -- requirements
Module: output_adc

Interface
REQ-001 The block SHALL have parameter NUM_COL, default 8, giving the number of parallel ADC serial lanes (one per memristor column).
REQ-002 The block SHALL have parameter DATA_W, default 12, giving the ADC word width in bits.
REQ-003 The block SHALL have parameter CONV_T, default 40, giving the conversion wait in clk cycles; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-005 The block SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, toggle request; a request is pending while start != finish.
REQ-007 The block SHALL have port SDO, input, NUM_COL, ADC serial data, one bit per lane, MSB first.
REQ-008 The block SHALL have port CS_N, output, 1, ADC convert-start / chip-select, active-low, registered.
REQ-009 The block SHALL have port SCLK, output, 1, ADC serial clock, registered (never gated from clk).
REQ-010 The block SHALL have port ADC_DATA, output, NUM_COL x DATA_W, last completed word per lane.
REQ-011 The block SHALL have port finish, output, 1, completion toggle, registered.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, CONV, SHIFT and DONE.
REQ-014 IDLE SHALL hold CS_N=1 and SCLK=0; on a posedge seeing start^finish=1 (edge E0) it SHALL go to CONV with CS_N<=0 and the counter cleared.
REQ-015 CONV SHALL last exactly CONV_T cycles with SCLK=0; the edge leaving CONV (E0+CONV_T) SHALL enter SHIFT and set SCLK<=1.
REQ-016 In SHIFT, on each edge with SCLK=1 the block SHALL set SCLK<=0 and shift SDO[i] into the LSB of lane i's shift register; on each edge with SCLK=0 it SHALL set SCLK<=1.
REQ-017 The block SHALL take exactly DATA_W samples, at edges E0+CONV_T+1+2k for k=0..DATA_W-1.
REQ-018 The last sample edge SHALL enter DONE with SCLK=0, giving exactly DATA_W SCLK rising edges per CS_N-low window.
REQ-019 The DONE edge (E0+CONV_T+2*DATA_W) SHALL, in the same cycle, load ADC_DATA from the shift registers, toggle finish, set CS_N<=1 and return to IDLE.
REQ-020 The ADC timing contract SHALL be: MSB valid at end of conversion, SDO updated by the ADC on SCLK falling edge, block samples on the edge that drives SCLK high-to-low.
REQ-021 ADC_DATA SHALL change only in DONE and SHALL hold its value at all other times.
REQ-022 Start toggles while busy SHALL be ignored; pending status SHALL be re-evaluated only in IDLE.
REQ-023 An even number of start toggles while busy SHALL cancel (no further conversion); an odd number SHALL leave one request pending.
REQ-024 A request pending on the IDLE edge immediately after DONE SHALL start the next conversion at that edge (one IDLE cycle between conversions).
REQ-025 The conversion wait counter SHALL be 8 bits and the bit counter SHALL be ceil(log2(DATA_W)) bits, with no wrap-around within a conversion.

Reset
REQ-026 While rstn=0, the block SHALL hold state=IDLE, CS_N=1, SCLK=0, finish=0, busy=0, all counters 0, and all shift registers and ADC_DATA lanes 0.
REQ-027 Reset mid-conversion SHALL abort immediately with no finish toggle and no ADC_DATA update.
REQ-028 If start=1 at reset release, a request SHALL be pending and the block SHALL begin a conversion on the first posedge after release.

Verification
REQ-029 The bench SHALL cover reset: rstn=0 -> CS_N=1, SCLK=0, finish=0, busy=0, ADC_DATA all 12'h000.
REQ-030 The bench SHALL cover a single conversion: start 0->1; ADC model returns 12'hA5C on lane 0 and 12'h001 on lane 7 -> finish=1 exactly 64 edges after E0 with ADC_DATA[0]=12'hA5C and ADC_DATA[7]=12'h001, and CS_N low for 64 cycles.
REQ-031 The bench SHALL cover a second request: start 1->0 with lane 0 returning 12'hFFF -> finish returns to 0 and ADC_DATA[0]=12'hFFF.
REQ-032 The bench SHALL cover a start toggle during SHIFT: one toggle -> current result unaffected, next conversion starts one cycle after DONE; two toggles -> no second conversion, busy=0.
REQ-033 The bench SHALL cover reset in SHIFT after 5 samples -> outputs take reset values at once and finish stays 0; after release with start=1 a full 12-bit conversion completes.
REQ-034 The bench SHALL check SCLK per conversion: exactly 12 rising edges, all with CS_N=0, none during CONV.
